multi_clk_div: RTL

//  Parametrised N-channel clock divider / tick generator; successor of the fixed two-output divider.

---
 rtl/multi_clk_div.sv | 76 +++++++
 1 files changed

// File: rtl/multi_clk_div.sv
// multi_clk_div: N-channel programmable clock divider / tick generator with glitch-free divisor updates
// Define CLKDIV_SYNC_EN to build the sync phase-align input; otherwise sync is ignored.
module multi_clk_div #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 25,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {25'd10000, 25'd25},
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d, tick_q, tick_d, pf_q, pf_d;
  logic [NUM_CH-1:0] wr, run, fire, apply;
  logic sync_act;
`ifdef CLKDIV_SYNC_EN
  assign sync_act = sync;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign sync_act = 1'b0;
`endif
  // A pending divisor lands whenever the counter restarts: terminal count, disable or sync.
  always_comb begin
    wr = '0;
    run = '0;
    fire = '0;
    apply = '0;
    cnt_d = cnt_q;
    div_d = div_q;
    pend_d = pend_q;
    clk_d = clk_q;
    tick_d = '0;
    pf_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = cfg_we && (32'(cfg_ch) < NUM_CH) && (32'(cfg_ch) == i);
      run[i] = ch_en[i] && !sync_act;
      fire[i] = run[i] && (cnt_q[i] == div_q[i]);
      apply[i] = !run[i] || fire[i];
      cnt_d[i] = (run[i] && !fire[i]) ? cnt_q[i] + 1'b1 : '0;
      clk_d[i] = sync_act ? 1'b0 : clk_q[i] ^ fire[i];
      tick_d[i] = fire[i];
      div_d[i] = (wr[i] && !run[i]) ? cfg_div : (apply[i] && pf_q[i]) ? pend_q[i] : div_q[i];
      pend_d[i] = wr[i] ? cfg_div : pend_q[i];
      pf_d[i] = run[i] && (wr[i] || (pf_q[i] && !fire[i]));
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= DEF_DIV;
      pend_q <= DEF_DIV;
      clk_q <= '0;
      tick_q <= '0;
      pf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      pend_q <= pend_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
      pf_q <= pf_d;
    end
  end
  assign clk_out = clk_q;
  assign tick = tick_q;
  assign cfg_pending = pf_q;
endmodule
